// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the execute/write-back boundary.
//   DATA_W        ALU result width
//   DST_W         destination register tag width
//   FLAG_*        bit positions inside the {Z,N,V,C} flag nibble
//   entry_t       one buffered result-stage entry {result, dst, wr_en, flags}
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int DST_W  = 3;
  localparam int FLAG_W = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DST_W-1:0]  dst;
    logic              wr_en;
    logic [FLAG_W-1:0] flags;
  } entry_t;

endpackage

// File: rtl/result_skid_buf.sv
// result_skid_buf: generic 2-entry in-order valid/ready skid buffer with flush.
//   clk_i, rst_i    clock (rising edge), asynchronous active-high reset
//   valid_i/data_i  upstream entry; ready_o is the registered "skid empty"
//   flush_i         invalidate both entries at the next edge, discard accept
//   valid_o/data_o  head entry; ready_i is the downstream accept
// Payload registers are never cleared by draining, so data_o holds its last
// value while valid_o is low.
module result_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  input  logic         flush_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         head_vld_q, head_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         drain;

  // ready depends only on state, so a full buffer never accepts even while
  // it drains; this keeps ready_o free of any path from ready_i.
  assign ready_o = ~skid_vld_q;
  assign valid_o = head_vld_q;
  assign data_o  = head_q;

  assign accept = valid_i & ~skid_vld_q;
  assign drain  = head_vld_q & ready_i;

  always_comb begin
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    head_d     = head_q;
    skid_d     = skid_q;
    if (flush_i) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (drain) begin
        head_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (head_vld_q) begin
      if (accept && drain) begin
        head_d = data_i;
      end else if (accept) begin
        skid_d     = data_i;
        skid_vld_d = 1'b1;
      end else if (drain) begin
        head_vld_d = 1'b0;
      end
    end else if (accept) begin
      head_d     = data_i;
      head_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registers the ALU result, write-back tag and derived
// {Z,N,V,C} flags behind a 2-entry skid buffer, and owns the architectural
// flag register read by the branch unit.
//   in_*            ALU result, Ofl, C_out, tag, write/flag enables + valid/ready
//   flush           squash all buffered entries and any same-cycle accept
//   out_*           head entry payload and valid/ready
//   flags_q         architectural flags {Z,N,V,C}
// Build option ALU_FLAG_BYPASS_EN: flags_q forwards the flags of a
// same-cycle flag-updating accept combinationally; otherwise flags_q is the
// flag register itself and updates one cycle after the accept.
module alu_result_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int DST_W  = cpu_pkg::DST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_ofl,
  input  logic              in_cout,
  input  logic [DST_W-1:0]  in_dst,
  input  logic              in_wr_en,
  input  logic              in_flag_en,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DST_W-1:0]  out_dst,
  output logic              out_wr_en,
  output logic [3:0]        out_flags,
  output logic [3:0]        flags_q
);

  import cpu_pkg::*;

  entry_t     in_entry;
  entry_t     head_entry;
  logic [3:0] in_flags;
  logic       accept;
  logic       flag_upd;
  logic [3:0] flag_reg_q, flag_reg_d;

  always_comb begin
    in_flags         = '0;
    in_flags[FLAG_Z] = (in_result == '0);
    in_flags[FLAG_N] = in_result[DATA_W-1];
    in_flags[FLAG_V] = in_ofl;
    in_flags[FLAG_C] = in_cout;
  end

  always_comb begin
    in_entry        = '0;
    in_entry.result = in_result;
    in_entry.dst    = in_dst;
    in_entry.wr_en  = in_wr_en;
    in_entry.flags  = in_flags;
  end

  result_skid_buf #(
    .W($bits(entry_t))
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  (in_entry),
    .flush_i (flush),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (head_entry)
  );

  assign out_result = head_entry.result;
  assign out_dst    = head_entry.dst;
  assign out_wr_en  = head_entry.wr_en;
  assign out_flags  = head_entry.flags;

  // Flags follow accept order; a flushed accept never reaches the register,
  // and already-accepted updates are not rolled back.
  assign accept   = in_valid & in_ready;
  assign flag_upd = accept & in_flag_en & ~flush;

  always_comb begin
    flag_reg_d = flag_reg_q;
    if (flag_upd) begin
      flag_reg_d = in_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_reg_q <= '0;
    end else begin
      flag_reg_q <= flag_reg_d;
    end
  end

`ifdef ALU_FLAG_BYPASS_EN
  assign flags_q = flag_upd ? in_flags : flag_reg_q;
`else
  assign flags_q = flag_reg_q;
`endif

endmodule
